// File: rtl/grid_window_gen.sv
// 3x3 sliding window generator over a raster pixel stream.
// Two line buffers supply the rows above; outputs are registered one edge after acceptance.
module grid_window_gen #(
   parameter int LINE_WIDTH   = 640,
   parameter int FRAME_HEIGHT = 480
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [9:0]  iPixel,
   input  logic        iValid,
   input  logic        iSof,
   output logic [89:0] oGrid,
   output logic        oValid,
   output logic [9:0]  oX,
   output logic [9:0]  oY
);

   localparam int AW = (LINE_WIDTH > 1) ? $clog2(LINE_WIDTH) : 1;

   logic [9:0]           col, row;
   logic [9:0]           col_eff, row_eff;
   logic [9:0]           col_next, row_next;
   logic [AW-1:0]        addr;
   logic [9:0]           lb0_rd, lb1_rd;
   logic                 win_valid;
   logic [2:0][2:0][9:0] win;

   logic [9:0] lb0 [LINE_WIDTH];
   logic [9:0] lb1 [LINE_WIDTH];

   // A start-of-frame pixel is placed at (0,0) whatever the counters say.
   always_comb begin
      col_eff   = iSof ? 10'd0 : col;
      row_eff   = iSof ? 10'd0 : row;
      col_next  = col_eff + 10'd1;
      row_next  = row_eff;
      if (col_eff == 10'(LINE_WIDTH - 1)) begin
         col_next = 10'd0;
         row_next = (row_eff == 10'(FRAME_HEIGHT - 1)) ? 10'd0 : row_eff + 10'd1;
      end
      addr      = col_eff[AW-1:0];
      lb0_rd    = lb0[addr];
      lb1_rd    = lb1[addr];
      win_valid = (row_eff >= 10'd2) && (col_eff >= 10'd2);
   end

   // NOTE: line buffers carry no reset so they map onto RAM; stale contents are masked by win_valid.
   always_ff @(posedge clock) begin
      if (iValid) begin
         lb1[addr] <= lb0_rd;
         lb0[addr] <= iPixel;
      end
   end

   // NOTE: all state uses non-blocking assignments so the shift reads pre-edge window values.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         col    <= '0;
         row    <= '0;
         win    <= '0;
         oValid <= 1'b0;
         oX     <= '0;
         oY     <= '0;
      end else begin
         oValid <= 1'b0;
         if (iValid) begin
            col <= col_next;
            row <= row_next;
            for (int r = 0; r < 3; r++) begin
               win[r][2] <= win[r][1];
               win[r][1] <= win[r][0];
            end
            win[0][0] <= iPixel;
            win[1][0] <= lb0_rd;
            win[2][0] <= lb1_rd;
            oValid    <= win_valid;
            if (win_valid) begin
               oX <= col_eff - 10'd1;
               oY <= row_eff - 10'd1;
            end
         end
      end
   end

   // Element k = 3*r + c lands at bits [10k+9:10k] through the packed layout.
   assign oGrid = win;

endmodule
